// File: rtl/jk_mon_pkg.sv
// Shared definitions for the JK latch monitor: FSM encoding, JK input codes,
// settle counter width and the JK next-state helper.
package jk_mon_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RACE   = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int SETTLE_W = 8;

  // Latch value predicted by the JK truth table; toggle is handled by the FSM
  function automatic logic jk_next(input logic [1:0] jk, input logic cur);
    case (jk)
      JK_SET:   jk_next = 1'b1;
      JK_RESET: jk_next = 1'b0;
      default:  jk_next = cur;
    endcase
  endfunction

endpackage

// File: rtl/jk_mon_if.sv
// Observation bus between a JK latch (plus its driver) and the monitor.
// master: drives the latch pins and reads results; slave: the monitor.
interface jk_mon_if #(
  parameter int CNT_W = 16
);
  logic             J;
  logic             K;
  logic             Q;
  logic             QB;
  logic             chk_valid;
  logic             err_compl;
  logic             err_state;
  logic             osc_det;
  logic [CNT_W-1:0] err_count;

  modport master (
    output J, K, Q, QB,
    input  chk_valid, err_compl, err_state, osc_det, err_count
  );

  modport slave (
    input  J, K, Q, QB,
    output chk_valid, err_compl, err_state, osc_det, err_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Plain two-stage shift toward the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/jk_latch_monitor.sv
// Clocked observer of a JK latch: samples J/K/Q/QB, predicts Q from the JK
// truth table, flags non-complement and wrong-state outputs, detects J=K=1
// race oscillation.
// Build option: JK_MON_SYNC_EN selects 2-flop synchronisers on every input
// (board use); without it each input gets one register stage (sim only).
module jk_latch_monitor
  import jk_mon_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int OSC_THRESH = 3,
  parameter int CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  jk_mon_if.slave  bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC);
  localparam logic [SETTLE_W-1:0] INIT_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [SETTLE_W-1:0] OSC_LIM   = SETTLE_W'(OSC_THRESH);

  logic [3:0] raw, smp;
  assign raw = {bus.J, bus.K, bus.Q, bus.QB};

`ifdef JK_MON_SYNC_EN
  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (raw[i]),
      .q     (smp[i])
    );
  end
`else
  // Single capture stage; only safe when the latch model is clk-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smp <= '0;
    else        smp <= raw;
  end
`endif

  logic [1:0] jk;
  logic       qs, qbs;
  assign jk  = smp[3:2];
  assign qs  = smp[1];
  assign qbs = smp[0];

  state_t              state;
  logic                exp_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] race_cnt;
  logic [1:0]          jk_prev;
  logic                qs_prev;
  logic                from_race;
  logic                chk_valid_q, err_compl_q, err_state_q, osc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic jk_chg, compl_bad, state_bad;
  assign jk_chg    = (jk != jk_prev);
  assign compl_bad = (qs == qbs);
  assign state_bad = (qs != exp_q);

  // Monitor FSM with expected-Q tracking, settle/race counters and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      exp_q       <= 1'b0;
      settle_cnt  <= '0;
      race_cnt    <= '0;
      jk_prev     <= JK_HOLD;
      qs_prev     <= 1'b0;
      from_race   <= 1'b0;
      chk_valid_q <= 1'b0;
      err_compl_q <= 1'b0;
      err_state_q <= 1'b0;
      osc_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      jk_prev     <= jk;
      qs_prev     <= qs;
      err_compl_q <= 1'b0;
      err_state_q <= 1'b0;
      case (state)
        // Wait for a stable complementary pair before trusting Q
        ST_INIT: begin
          if (qs != qbs) begin
            if (settle_cnt == INIT_LAST) begin
              settle_cnt <= '0;
              if (jk == JK_TOGGLE) begin
                state    <= ST_RACE;
                race_cnt <= '0;
              end else begin
                state       <= ST_CHECK;
                exp_q       <= qs;
                chk_valid_q <= 1'b1;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end else begin
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (jk_chg) begin
            settle_cnt <= SETTLE_LD;
          end else if (settle_cnt == '0) begin
            if (jk == JK_TOGGLE) begin
              state    <= ST_RACE;
              race_cnt <= '0;
            end else begin
              state       <= ST_CHECK;
              chk_valid_q <= 1'b1;
              from_race   <= 1'b0;
              // After a race the held value is arbitrary: adopt it
              exp_q       <= (from_race && jk == JK_HOLD) ? qs : jk_next(jk, exp_q);
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (jk_chg) begin
            state       <= ST_SETTLE;
            settle_cnt  <= SETTLE_LD;
            chk_valid_q <= 1'b0;
          end else begin
            exp_q <= jk_next(jk, exp_q);
            if (compl_bad || state_bad) begin
              err_compl_q <= compl_bad;
              err_state_q <= !compl_bad;
              if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RACE: begin
          if (jk_chg) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LD;
            from_race  <= 1'b1;
          end else if (qs != qs_prev && race_cnt != OSC_LIM) begin
            race_cnt <= race_cnt + 1'b1;
            if (race_cnt == OSC_LIM - 1'b1) osc_q <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.chk_valid = chk_valid_q;
  assign bus.err_compl = err_compl_q;
  assign bus.err_state = err_state_q;
  assign bus.osc_det   = osc_q;
  assign bus.err_count = cnt_q;

endmodule
